// File: rtl/jesd_tx_pkg.sv
// Shared definitions for the JESD204B TX link layer: control characters, link states
// and ILAS geometry.
package jesd_tx_pkg;

  localparam logic [7:0] K28_0 = 8'h1C;  // /R/ multiframe start
  localparam logic [7:0] K28_3 = 8'h7C;  // /A/ multiframe end
  localparam logic [7:0] K28_4 = 8'h9C;  // /Q/ config marker
  localparam logic [7:0] K28_5 = 8'hBC;  // /K/ code-group sync
  localparam logic [7:0] K28_7 = 8'hFC;  // /F/ frame end

  // Encoding doubles as the encoder link-mux select.
  typedef enum logic [2:0] {
    StCgs  = 3'd0,
    StIlas = 3'd1,
    StData = 3'd2
  } link_state_e;

  localparam int unsigned IlasMfs = 4;
  localparam int unsigned CfgLen  = 14;

endpackage

// File: rtl/tx_lmfc_counter.sv
// Free-running LMFC counter. Outputs describe the slot being loaded into the output
// registers on the coming edge, so they line up with the registered octet.
module tx_lmfc_counter #(
  parameter int unsigned F = 1,
  parameter int unsigned K = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] cnt,
  output logic       frame_end,
  output logic       mf_end,
  output logic       boundary
);

  localparam int unsigned MfLen = F * K;

  logic [7:0] cnt_q;
  logic [2:0] frm_q, frm_d;

  always_comb begin
    boundary  = (cnt_q == 8'(MfLen - 1));
    cnt       = boundary ? 8'd0 : cnt_q + 8'd1;
    frm_d     = (boundary || frm_q == 3'(F - 1)) ? 3'd0 : frm_q + 3'd1;
    frame_end = (frm_d == 3'(F - 1));
    mf_end    = (cnt == 8'(MfLen - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
      frm_q <= 3'd0;
    end else begin
      cnt_q <= cnt;
      frm_q <= frm_d;
    end
  end

endmodule

// File: rtl/tx_link_ctrl.sv
// JESD204B TX link control: CGS, LMFC-aligned 4-multiframe ILAS, then user data.
// Build macro TX_CHAR_REPLACE_EN enables end-of-frame /F/ and /A/ character replacement.
module tx_link_ctrl
  import jesd_tx_pkg::*;
#(
  parameter int unsigned F = 1,
  parameter int unsigned K = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_sync_n,
  input  logic [8*CfgLen-1:0]   i_cfg,
  input  logic [7:0]            i_user_data,
  input  logic                  i_user_vld,
  output logic                  o_user_rdy,
  output logic [7:0]            o_data,
  output logic                  o_vld,
  output logic                  o_k,
  output logic [2:0]            o_link_mux,
  output logic                  o_lmfc
);

  link_state_e state_q, state_d;
  logic [1:0]   mf_q, mf_d;
  logic         sync_q;
  logic [7:0]   user_data_q;
  logic         user_vld_q;
  logic [7:0]   slot_cnt;
  logic         frame_end, mf_end, boundary;
  logic [7:0]   data_d, user_oct, cfg_byte;
  logic         k_d;
  logic [3:0]   cfg_sel;
  logic [127:0] cfg_pad;

  assign cfg_pad = {{(128 - 8 * CfgLen){1'b0}}, i_cfg};

  tx_lmfc_counter #(
    .F (F),
    .K (K)
  ) u_lmfc (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnt       (slot_cnt),
    .frame_end (frame_end),
    .mf_end    (mf_end),
    .boundary  (boundary)
  );

  always_comb begin
    state_d = state_q;
    mf_d    = mf_q;
    case (state_q)
      StCgs: begin
        if (sync_q && boundary) begin
          state_d = StIlas;
          mf_d    = 2'd0;
        end
      end
      StIlas: begin
        if (!sync_q) begin
          state_d = StCgs;
          mf_d    = 2'd0;
        end else if (boundary) begin
          if (mf_q == 2'(IlasMfs - 1)) begin
            state_d = StData;
            mf_d    = 2'd0;
          end else begin
            mf_d = mf_q + 2'd1;
          end
        end
      end
      StData: begin
        if (!sync_q) state_d = StCgs;
      end
      default: begin
        state_d = StCgs;
        mf_d    = 2'd0;
      end
    endcase
  end

`ifdef TX_CHAR_REPLACE_EN
  logic [7:0] prev_q, prev_d;
`else
  logic unused_frame_end;
  assign unused_frame_end = frame_end;
`endif

  // Octet for the slot being loaded, decoded from the next state so a state change
  // and its first octet appear together.
  always_comb begin
    data_d   = K28_5;
    k_d      = 1'b1;
    user_oct = user_vld_q ? user_data_q : 8'h00;
    cfg_sel  = 4'(slot_cnt - 8'd2);
    cfg_byte = cfg_pad[{cfg_sel, 3'b000} +: 8];
`ifdef TX_CHAR_REPLACE_EN
    prev_d   = prev_q;
`endif
    case (state_d)
      StIlas: begin
        if (slot_cnt == 8'd0) begin
          data_d = K28_0;
        end else if (mf_end) begin
          data_d = K28_3;
        end else if (mf_d == 2'd1 && slot_cnt == 8'd1) begin
          data_d = K28_4;
        end else begin
          k_d    = 1'b0;
          data_d = (mf_d == 2'd1 && slot_cnt >= 8'd2 && slot_cnt < 8'(CfgLen + 2)) ?
                   cfg_byte : slot_cnt;
        end
      end
      StData: begin
        data_d = user_oct;
        k_d    = 1'b0;
`ifdef TX_CHAR_REPLACE_EN
        // Idle fill never takes part in replacement; compare against unreplaced octets.
        if (state_q != StData) begin
          prev_d = 8'h00;
        end else if (user_vld_q && frame_end) begin
          prev_d = user_oct;
          if (user_oct == prev_q) begin
            data_d = mf_end ? K28_3 : K28_7;
            k_d    = 1'b1;
          end
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 1'b0;
      state_q     <= StCgs;
      mf_q        <= 2'd0;
      user_data_q <= 8'h00;
      user_vld_q  <= 1'b0;
      o_data      <= 8'h00;
      o_vld       <= 1'b0;
      o_k         <= 1'b0;
      o_link_mux  <= 3'd0;
      o_user_rdy  <= 1'b0;
      o_lmfc      <= 1'b0;
`ifdef TX_CHAR_REPLACE_EN
      prev_q      <= 8'h00;
`endif
    end else begin
      sync_q      <= i_sync_n;
      state_q     <= state_d;
      mf_q        <= mf_d;
      user_data_q <= i_user_data;
      user_vld_q  <= o_user_rdy & i_user_vld;
      o_data      <= data_d;
      o_vld       <= 1'b1;
      o_k         <= k_d;
      o_link_mux  <= state_d;
      o_user_rdy  <= (state_d == StData);
      o_lmfc      <= boundary;
`ifdef TX_CHAR_REPLACE_EN
      prev_q      <= prev_d;
`endif
    end
  end

endmodule

// File: tb/tb_tx_link_ctrl.sv
// Scoreboard bench for tx_link_ctrl (F=1, K=32): CGS, ILAS alignment/content, data path,
// replacement behaviour (both builds), resync and asynchronous reset.
module tb_tx_link_ctrl;

  localparam int unsigned MfLen = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_sync_n = 1'b0;
  logic [111:0] i_cfg;
  logic [7:0]   i_user_data = 8'h00;
  logic         i_user_vld = 1'b0;
  logic         o_user_rdy, o_vld, o_k, o_lmfc;
  logic [7:0]   o_data;
  logic [2:0]   o_link_mux;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned bench_cnt = 0;

  logic [13:0] exp_q[$];
  logic        lmfc_q[$];
  logic [7:0]  sd[$];
  logic        sv[$];

  tx_link_ctrl #(
    .F (1),
    .K (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_sync_n    (i_sync_n),
    .i_cfg       (i_cfg),
    .i_user_data (i_user_data),
    .i_user_vld  (i_user_vld),
    .o_user_rdy  (o_user_rdy),
    .o_data      (o_data),
    .o_vld       (o_vld),
    .o_k         (o_k),
    .o_link_mux  (o_link_mux),
    .o_lmfc      (o_lmfc)
  );

  always #5 clk = ~clk;

  // Reference LMFC count: edges since reset release, modulo the multiframe length.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bench_cnt <= 0;
    else        bench_cnt <= (bench_cnt == MfLen - 1) ? 0 : bench_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] obs();
    return {o_vld, o_k, o_user_rdy, o_link_mux, o_data};
  endfunction

  function automatic logic [13:0] pk(input logic v, input logic k, input logic r,
                                     input logic [2:0] m, input logic [7:0] d);
    return {v, k, r, m, d};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] e;
    logic [7:0]  last_v;
    int          n;
    int          slot;

    for (int i = 0; i < 14; i++) i_cfg[8*i +: 8] = 8'hA0 + 8'(i);

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_out", obs(), pk(0, 0, 0, 0, 8'h00));
    check_eq("rst_lmfc", o_lmfc, 0);
    rst_n = 1'b1;

    // CGS while sync requested
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check_eq($sformatf("cgs_%0d", i), obs(), pk(1, 1, 0, 0, 8'hBC));
      check_eq($sformatf("cgs_lmfc_%0d", i), o_lmfc, bench_cnt == 0);
    end

    // ILAS: release sync at count 10, expect 128 octets starting at the LMFC pulse
    n = 0;
    while (bench_cnt != 10 && n < 64) begin @(negedge clk); n++; end
    i_sync_n = 1'b1;
    for (int m = 0; m < 4; m++) begin
      for (int j = 0; j < 32; j++) begin
        if (j == 0)                        e = pk(1, 1, 0, 1, 8'h1C);
        else if (j == 31)                  e = pk(1, 1, 0, 1, 8'h7C);
        else if (m == 1 && j == 1)         e = pk(1, 1, 0, 1, 8'h9C);
        else if (m == 1 && j <= 15)        e = pk(1, 0, 0, 1, 8'hA0 + 8'(j - 2));
        else                               e = pk(1, 0, 0, 1, 8'(j));
        exp_q.push_back(e);
        lmfc_q.push_back(j == 0);
      end
    end
    n = 0;
    while (o_link_mux != 3'd1 && n < 64) begin @(negedge clk); n++; end
    check_eq("ilas_start_mux", o_link_mux, 1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      check_eq($sformatf("ilas_%0d", i), obs(), exp_q.pop_front());
      check_eq($sformatf("ilas_lmfc_%0d", i), o_lmfc, lmfc_q.pop_front());
      @(negedge clk);
    end

    // First DATA octet is idle fill
    check_eq("data_entry", obs(), pk(1, 0, 1, 2, 8'h00));

    // Data path: 0x11, 0x22, gap, 0x33, idles, then constant 0x55
    sd = '{8'h11, 8'h22, 8'hEE, 8'h33, 8'h00, 8'h00};
    sv = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 40; i++) begin sd.push_back(8'h55); sv.push_back(1'b1); end
    sd.push_back(8'h00); sv.push_back(1'b0);
    last_v = 8'h00;
    exp_q.push_back(pk(1, 0, 1, 2, 8'h00));
    for (int i = 0; i < sd.size(); i++) begin
      i_user_data = sd[i];
      i_user_vld  = sv[i];
      slot = (bench_cnt + 2) % MfLen;
      if (!sv[i]) begin
        e = pk(1, 0, 1, 2, 8'h00);
      end else begin
`ifdef TX_CHAR_REPLACE_EN
        if (sd[i] == last_v) e = pk(1, 1, 1, 2, (slot == MfLen - 1) ? 8'h7C : 8'hFC);
        else                 e = pk(1, 0, 1, 2, sd[i]);
        last_v = sd[i];
`else
        e = pk(1, 0, 1, 2, sd[i]);
`endif
      end
      exp_q.push_back(e);
      @(negedge clk);
      check_eq($sformatf("data_%0d", i), obs(), exp_q.pop_front());
    end
    i_user_vld = 1'b0;
    @(negedge clk);
    check_eq("data_drain", obs(), exp_q.pop_front());

    // Resync: BC two cycles after SYNC~ falls
    i_sync_n = 1'b0;
    @(negedge clk);
    check_eq("resync_lag", o_link_mux, 2);
    @(negedge clk);
    check_eq("resync_cgs", obs(), pk(1, 1, 0, 0, 8'hBC));
    repeat (3) @(negedge clk);
    i_sync_n = 1'b1;
    n = 0;
    while (o_link_mux != 3'd1 && n < 80) begin @(negedge clk); n++; end
    check_eq("reilas_start", obs(), pk(1, 1, 0, 1, 8'h1C));
    check_eq("reilas_lmfc", o_lmfc, 1);
    @(negedge clk);
    check_eq("reilas_j1", obs(), pk(1, 0, 0, 1, 8'h01));

    // Asynchronous reset mid-operation
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_out", obs(), pk(0, 0, 0, 0, 8'h00));
    check_eq("async_rst_lmfc", o_lmfc, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
